input_debounce: RTL and testbench
=================================

# input_debounce

Front-end conditioning stage for single-bit external inputs (buttons, straps, slow status lines). It synchronises an asynchronous raw input into `clk`, rejects bounce and glitches with a consecutive-sample qualification counter, and produces a clean registered level plus one-cycle rise/fall pulses. The clean level is the data input of the downstream flop stage, so that stage only ever sees a synchronous, debounced signal.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a new level; legal values are 1 or more.
- `CNT_W`, derived localparam = `$clog2(DEBOUNCE_CYCLES+1)`: qualification counter width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_i`  in  1  raw input, asynchronous to `clk`.
- `level_o`  out  1  debounced level; drives the downstream stage's `d_i`.
- `rise_o`  out  1  one-cycle pulse in the cycle `level_o` goes 0→1.
- `fall_o`  out  1  one-cycle pulse in the cycle `level_o` goes 1→0.
- `busy_o`  out  1  high while a candidate level is being qualified.

## Operation
- `raw_i` passes through a `SYNC_STAGES`-deep flop chain. `sync_s` is the last stage; `raw_i` is never used anywhere else.
- FSM states:
  - `LOW_STABLE`: `level_o` = 0.
  - `QUAL_HIGH`: `level_o` = 0, `busy_o` = 1.
  - `HIGH_STABLE`: `level_o` = 1.
  - `QUAL_LOW`: `level_o` = 1, `busy_o` = 1.
- In `LOW_STABLE`, `sync_s` = 1:
  - If `DEBOUNCE_CYCLES` = 1, go to `HIGH_STABLE` and pulse `rise_o`.
  - Otherwise go to `QUAL_HIGH` with cnt = 1.
- In `QUAL_HIGH`:
  - `sync_s` = 0: return to `LOW_STABLE`, cnt = 0. This is glitch rejection; no pulse is produced.
  - `sync_s` = 1 and cnt+1 = `DEBOUNCE_CYCLES`: go to `HIGH_STABLE`, pulse `rise_o`, cnt = 0.
  - `sync_s` = 1 otherwise: cnt increments.
- `HIGH_STABLE` and `QUAL_LOW` behave symmetrically with `sync_s` inverted and `fall_o` in place of `rise_o`.
- Any single sample that disagrees with the candidate level aborts qualification; the counter restarts from zero the next time the candidate level is seen.
- cnt never exceeds `DEBOUNCE_CYCLES`−1, so the counter cannot overflow.
- All outputs are registered. `rise_o` and `fall_o` are mutually exclusive and never high for two consecutive cycles.
- Reset values:
  - All synchroniser flops = 0.
  - State = `LOW_STABLE`, cnt = 0.
  - `level_o` = `rise_o` = `fall_o` = `busy_o` = 0.
- Reset mid-operation:
  - All state clears immediately and asynchronously; no pulse is emitted at assertion or at release.
  - If `raw_i` is high at release, a full qualification runs and a `rise_o` follows.

## Timing
- Edge numbering: edge 1 is the first `clk` edge at which `raw_i` is stably high (met setup).
- `sync_s` is high after edge `SYNC_STAGES`.
- `level_o` and `rise_o` assert after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults this is 18 cycles.
- `busy_o` is high for exactly `DEBOUNCE_CYCLES`−1 cycles before acceptance, and is never high when `DEBOUNCE_CYCLES` = 1.
- The falling direction has identical latency.
- A `raw_i` pulse is rejected if it is shorter than `DEBOUNCE_CYCLES` synchronised samples. Pulses within ±1 cycle of that threshold may resolve either way because of synchroniser uncertainty.
- Minimum spacing between `rise_o` and the following `fall_o` is `DEBOUNCE_CYCLES` cycles.

## Structure
- Shared include/package `debounce_pkg`:
  - 2-bit state encodings `ST_LOW_STABLE`=0, `ST_QUAL_HIGH`=1, `ST_HIGH_STABLE`=2, `ST_QUAL_LOW`=3.
  - Parameter legality checks.
- Sub-module `sync_ff`:
  - Parameter `STAGES`.
  - Asynchronous active-high reset to 0.
  - Reused by other CDC inputs.
- FSM, counter, and output registers live in `input_debounce`.

## Test plan
Bench parameters are `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4 unless stated otherwise.
- Clean rise: `raw_i` 0→1 before edge 1, then held → `busy_o` high after edges 3–5; `level_o`=1 and `rise_o`=1 after edge 6; `rise_o`=0 after edge 7.
- Glitch: `raw_i` high for 2 cycles from steady low → `level_o`, `rise_o`, and `fall_o` stay 0; `busy_o` returns to 0.
- Bounce: `raw_i` toggles every cycle for 10 cycles, then holds 1 → exactly one `rise_o`, 6 edges after the final toggle; no `fall_o`.
- Clean fall from `HIGH_STABLE`: `raw_i` 1→0 → `level_o`=0 and `fall_o` pulse 6 edges later; no `rise_o`.
- Reset in `QUAL_HIGH` (cnt=2) with `raw_i` held 1 → all outputs 0 immediately; after release, `rise_o` occurs 6 edges after the first post-release edge.
- `DEBOUNCE_CYCLES`=1: `raw_i` 0→1 → `level_o`=1 and `rise_o` after edge 3; `busy_o` never asserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debounce front end: FSM state encodings
// and the parameter legality test used at elaboration.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW_STABLE  = 2'd0,
        ST_QUAL_HIGH   = 2'd1,
        ST_HIGH_STABLE = 2'd2,
        ST_QUAL_LOW    = 2'd3
    } state_t;

    function automatic bit params_legal(input int sync_stages, input int debounce_cycles);
        return (sync_stages >= 2) && (debounce_cycles >= 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; all stages clear to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronises a raw asynchronous input, qualifies each new level over
// DEBOUNCE_CYCLES consecutive samples and emits registered level/edge pulses.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(DEBOUNCE_CYCLES);

    generate
        if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
            $error("input_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
        end
    endgenerate

    logic             sync_s;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, rise_reg, fall_reg, busy_reg;
    logic             level_next, rise_next, fall_next, busy_next;
    logic             qual_done;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_i),
        .q     (sync_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_LOW_STABLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    // The sample being accepted now is the last one needed when cnt+1 reaches the target.
    assign qual_done = (({1'b0, cnt_reg} + (CNT_W + 1)'(1)) == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_LOW_STABLE: begin
                if (sync_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = ST_HIGH_STABLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_QUAL_HIGH;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_QUAL_HIGH: begin
                if (!sync_s) begin
                    state_next = ST_LOW_STABLE;
                    cnt_next   = '0;
                end else if (qual_done) begin
                    state_next = ST_HIGH_STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HIGH_STABLE: begin
                if (!sync_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = ST_LOW_STABLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_QUAL_LOW;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_QUAL_LOW: begin
                if (sync_s) begin
                    state_next = ST_HIGH_STABLE;
                    cnt_next   = '0;
                end else if (qual_done) begin
                    state_next = ST_LOW_STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_LOW_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        level_next = (state_next == ST_HIGH_STABLE) || (state_next == ST_QUAL_LOW);
        busy_next  = (state_next == ST_QUAL_HIGH) || (state_next == ST_QUAL_LOW);
        rise_next  = ((state_reg == ST_LOW_STABLE) || (state_reg == ST_QUAL_HIGH))
                     && (state_next == ST_HIGH_STABLE);
        fall_next  = ((state_reg == ST_HIGH_STABLE) || (state_reg == ST_QUAL_LOW))
                     && (state_next == ST_LOW_STABLE);
    end

    assign level_o = level_reg;
    assign rise_o  = rise_reg;
    assign fall_o  = fall_reg;
    assign busy_o  = busy_reg;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: a DEBOUNCE_CYCLES=4 instance and a
// DEBOUNCE_CYCLES=1 instance share clock, reset and raw input.
module tb_input_debounce;

    logic clk;
    logic reset;
    logic raw;
    logic level4, rise4, fall4, busy4;
    logic level1, rise1, fall1, busy1;

    int errors = 0;
    int checks = 0;
    int rise4_cnt = 0;
    int fall4_cnt = 0;
    int busy1_seen = 0;
    int level4_seen = 0;

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw),
        .level_o (level4),
        .rise_o  (rise4),
        .fall_o  (fall4),
        .busy_o  (busy4)
    );

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw),
        .level_o (level1),
        .rise_o  (rise1),
        .fall_o  (fall1),
        .busy_o  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rise4 === 1'b1) rise4_cnt++;
        if (fall4 === 1'b1) fall4_cnt++;
        if (busy1 === 1'b1) busy1_seen++;
        if (level4 === 1'b1) level4_seen++;
    endtask

    int r0, f0;

    initial begin
        reset = 1'b1;
        raw   = 1'b0;
        tick();
        tick();
        check("reset_level", {level4, level1}, 0);
        check("reset_pulses", {rise4, fall4, rise1, fall1}, 0);
        check("reset_busy", {busy4, busy1}, 0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_after_reset", {level4, rise4, fall4, busy4}, 0);

        // Clean rise
        raw = 1'b1;
        tick();
        check("rise_e1_busy", busy4, 0);
        tick();
        check("rise_e2_busy", busy4, 0);
        tick();
        check("rise_e3_busy", busy4, 1);
        check("rise_e3_level", level4, 0);
        check("d1_rise_e3", {level1, rise1}, 2'b11);
        tick();
        check("rise_e4_busy", busy4, 1);
        check("d1_rise_e4_pulse_end", {level1, rise1}, 2'b10);
        tick();
        check("rise_e5_busy_norise", {busy4, rise4, level4}, 3'b100);
        tick();
        check("rise_e6", {level4, rise4, busy4, fall4}, 4'b1100);
        tick();
        check("rise_e7", {level4, rise4}, 2'b10);

        // Clean fall
        r0 = rise4_cnt;
        f0 = fall4_cnt;
        raw = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check("fall_e5_still_high", {level4, fall4, busy4}, 3'b101);
        tick();
        check("fall_e6", {level4, fall4, busy4}, 3'b010);
        tick();
        check("fall_e7", {level4, fall4}, 0);
        check("fall_no_rise", rise4_cnt - r0, 0);
        check("fall_one_fall", fall4_cnt - f0, 1);

        // Glitch: two cycles high from steady low
        r0 = rise4_cnt;
        f0 = fall4_cnt;
        level4_seen = 0;
        raw = 1'b1;
        tick();
        tick();
        raw = 1'b0;
        tick();
        tick();
        check("glitch_qualifying", busy4, 1);
        for (int i = 0; i < 6; i++) tick();
        check("glitch_busy_clear", busy4, 0);
        check("glitch_level_never", level4_seen, 0);
        check("glitch_no_pulses", (rise4_cnt - r0) + (fall4_cnt - f0), 0);

        // Bounce: ten alternating samples, then hold high
        r0 = rise4_cnt;
        f0 = fall4_cnt;
        for (int i = 0; i < 10; i++) begin
            raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        check("bounce_no_early_rise", rise4_cnt - r0, 0);
        raw = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check("bounce_e5", {level4, rise4}, 0);
        tick();
        check("bounce_e6", {level4, rise4}, 2'b11);
        for (int i = 0; i < 4; i++) tick();
        check("bounce_one_rise", rise4_cnt - r0, 1);
        check("bounce_no_fall", fall4_cnt - f0, 0);

        // Back to low, then reset while qualifying high with cnt=2
        raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("pre_reset_low", level4, 0);
        raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("pre_reset_qual", {busy4, level4}, 2'b10);
        r0 = rise4_cnt;
        f0 = fall4_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clears", {level4, rise4, fall4, busy4, level1, busy1}, 0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        check("post_release_e1", {level4, rise4, busy4}, 0);
        tick();
        tick();
        check("post_release_e3_busy", busy4, 1);
        check("post_release_d1", {level1, rise1}, 2'b11);
        tick();
        tick();
        check("post_release_e5", rise4, 0);
        tick();
        check("post_release_e6", {level4, rise4}, 2'b11);
        check("reset_no_extra_pulses", {rise4_cnt - r0, fall4_cnt - f0}, {32'd1, 32'd0});
        check("d1_busy_never", busy1_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
